// File: rtl/tx_frame_serializer.sv
// Serial frame transmitter: preamble, length header, scrambled SERVICE/payload/pad, zero tail.
// Optional header parity bit when TX_HDR_PARITY_EN is defined.
module tx_frame_serializer #(
   parameter int         PREAMBLE_LEN = 12,
   parameter int         LEN_W        = 12,
   parameter int         PAD_W        = 3,
   parameter int         SERVICE_LEN  = 16,
   parameter int         TAIL_LEN     = 6,
   parameter logic [6:0] SEED         = 7'h6F
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Enable,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic [PAD_W-1:0] num_pads,
   input  logic             data_in,
   input  logic             data_valid,
   output logic             data_ready,
   output logic             y,
   output logic             y_valid,
   output logic             busy,
   output logic             done
);

`ifdef TX_HDR_PARITY_EN
   localparam int HDR_LEN = LEN_W + 1;
`else
   localparam int HDR_LEN = LEN_W;
`endif
   localparam int CW = LEN_W + 3;

   typedef enum logic [2:0] {
      IDLE, PREAMBLE, HEADER, SERVICE, DATA, PAD, TAIL
   } state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt, cnt_inc;
   logic [LEN_W-1:0] len_q, hdr_sr;
   logic [PAD_W-1:0] pads_q;
   logic [6:0]       lfsr;
   logic             fb, scr, cnt_adv, bit_in;
   logic [CW-1:0]    data_bits, pad_bits;

   assign cnt_inc    = cnt + CW'(1);
   assign data_bits  = {len_q, 3'b000};
   assign pad_bits   = CW'({pads_q, 3'b000});
   assign fb         = lfsr[6] ^ lfsr[3];
   assign busy       = (state != IDLE);
   assign data_ready = (state == DATA);

   always_comb begin
      state_nxt = state;
      cnt_adv   = 1'b0;
      scr       = 1'b0;
      bit_in    = 1'b0;
      y         = 1'b0;
      y_valid   = 1'b0;
      case (state)
         IDLE: if (start) state_nxt = PREAMBLE;
         PREAMBLE: begin
            y       = 1'b1;
            y_valid = 1'b1;
            cnt_adv = 1'b1;
            if (cnt == CW'(PREAMBLE_LEN - 1)) state_nxt = HEADER;
         end
         HEADER: begin
            y_valid = 1'b1;
            cnt_adv = 1'b1;
            y       = hdr_sr[LEN_W-1];
`ifdef TX_HDR_PARITY_EN
            if (cnt == CW'(LEN_W)) y = ^len_q;
`endif
            if (cnt == CW'(HDR_LEN - 1)) state_nxt = SERVICE;
         end
         SERVICE: begin
            scr     = 1'b1;
            y_valid = 1'b1;
            cnt_adv = 1'b1;
            if (cnt == CW'(SERVICE_LEN - 1))
               state_nxt = (len_q != '0) ? DATA : (pads_q != '0) ? PAD : TAIL;
         end
         DATA: begin
            // stalls freeze counter and scrambler so no bit is dropped
            if (data_valid) begin
               scr     = 1'b1;
               y_valid = 1'b1;
               cnt_adv = 1'b1;
               bit_in  = data_in;
               if (cnt_inc == data_bits) state_nxt = (pads_q != '0) ? PAD : TAIL;
            end
         end
         PAD: begin
            scr     = 1'b1;
            y_valid = 1'b1;
            cnt_adv = 1'b1;
            if (cnt_inc == pad_bits) state_nxt = TAIL;
         end
         TAIL: begin
            y_valid = 1'b1;
            cnt_adv = 1'b1;
            if (cnt == CW'(TAIL_LEN - 1)) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (scr) y = bit_in ^ fb;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state  <= IDLE;
         cnt    <= '0;
         len_q  <= '0;
         pads_q <= '0;
         hdr_sr <= '0;
         lfsr   <= SEED;
         done   <= 1'b0;
      end else if (!Enable) begin
         // abort like reset, but the scrambler is left alone (reloaded at SERVICE anyway)
         state  <= IDLE;
         cnt    <= '0;
         len_q  <= '0;
         pads_q <= '0;
         hdr_sr <= '0;
         done   <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= (state == TAIL) && (state_nxt == IDLE);
         if (state_nxt != state) cnt <= '0;
         else if (cnt_adv)       cnt <= cnt_inc;
         if (state == IDLE && start) begin
            len_q  <= len;
            pads_q <= num_pads;
            hdr_sr <= len;
         end else if (state == HEADER) begin
            hdr_sr <= {hdr_sr[LEN_W-2:0], 1'b0};
         end
         if (state == HEADER && state_nxt == SERVICE) lfsr <= SEED;
         else if (scr)                                lfsr <= {lfsr[5:0], fb};
      end
   end

endmodule

// File: tb/tb_tx_frame_serializer.sv
// Directed bench for tx_frame_serializer: frame content, stalls, skips, reset abort, ignored start.
module tb_tx_frame_serializer;

   logic        Clk = 1'b0;
   logic        Reset, Enable, start, data_in, data_valid;
   logic [11:0] len;
   logic [2:0]  num_pads;
   logic        data_ready, y, y_valid, busy, done;

   int n_cmp = 0;
   int n_err = 0;

   bit     got[$];
   bit     exp_q[$];
   int     done_cyc, nv;
   bit     saw_ready;
   logic [7:0] pay [0:3] = '{8'hA5, 8'h3C, 8'hF0, 8'h81};

`ifdef TX_HDR_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif

   tx_frame_serializer #(.SEED(7'h7F)) dut (
      .Clk(Clk), .Reset(Reset), .Enable(Enable), .start(start), .len(len),
      .num_pads(num_pads), .data_in(data_in), .data_valid(data_valid),
      .data_ready(data_ready), .y(y), .y_valid(y_valid), .busy(busy), .done(done)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic bit pbit(input int k);
      logic [7:0] b;
      b = pay[k/8];
      return b[7 - (k % 8)];
   endfunction

   // reference stream built from the frame format and x^7+x^4+1 scrambler
   task automatic build_exp(input logic [11:0] l, input logic [2:0] p);
      logic [6:0] s;
      bit f;
      exp_q.delete();
      repeat (12) exp_q.push_back(1'b1);
      for (int i = 11; i >= 0; i--) exp_q.push_back(l[i]);
      if (PB == 1) exp_q.push_back(^l);
      s = 7'h7F;
      for (int i = 0; i < 16 + 8*int'(l) + 8*int'(p); i++) begin
         bit b;
         b = (i >= 16 && i < 16 + 8*int'(l)) ? pbit(i - 16) : 1'b0;
         f = s[6] ^ s[3];
         exp_q.push_back(b ^ f);
         s = {s[5:0], f};
      end
      repeat (6) exp_q.push_back(1'b0);
   endtask

   task automatic cmp_stream(input string name);
      logic [31:0] a, e;
      int idx;
      chk({name, "_nbits"}, got.size(), exp_q.size());
      for (int k = 0; k < (exp_q.size() + 31) / 32; k++) begin
         a = '0; e = '0;
         for (int j = 0; j < 32; j++) begin
            idx = k*32 + j;
            if (idx < got.size())   a[31-j] = got[idx];
            if (idx < exp_q.size()) e[31-j] = exp_q[idx];
         end
         chk($sformatf("%s_w%0d", name, k), a, e);
      end
   endtask

   // start at a negedge (cycle 0), then sample every following cycle until done
   task automatic run_frame(input logic [11:0] l, input logic [2:0] p,
                            input bit toggle, input bit hstart);
      bit tog;
      int pidx;
      got.delete();
      done_cyc = -1; nv = 0; saw_ready = 0; tog = 1; pidx = 0;
      len = l; num_pads = p; start = 1'b1;
      @(negedge Clk);
      start = 1'b0;
      for (int c = 1; c < 400 && done_cyc < 0; c++) begin
         if (hstart && c == 15) begin start = 1'b1; len = 12'hABC; num_pads = 3'd5; end
         else start = 1'b0;
         if (data_ready) begin
            saw_ready  = 1;
            data_valid = toggle ? tog : 1'b1;
            tog        = ~tog;
         end else data_valid = 1'b1;
         data_in = (pidx < 32) ? pbit(pidx) : 1'b0;
         #1;
         if (y_valid) begin got.push_back(y); nv++; end
         if (data_valid && data_ready) pidx++;
         if (done) done_cyc = c;
         @(negedge Clk);
      end
      if (done_cyc < 0) chk("frame_timeout", 0, 1);
   endtask

   initial begin
      logic [23:0] head;
      logic [7:0]  svc;
      int w;
      Reset = 1'b1; Enable = 1'b1; start = 1'b0; len = '0; num_pads = '0;
      data_in = 1'b0; data_valid = 1'b1;
      repeat (2) @(negedge Clk);
      chk("rst_y", y, 0);
      chk("rst_yv", y_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ready", data_ready, 0);
      Reset = 1'b0;
      @(negedge Clk);

      // Enable low blocks start
      Enable = 1'b0; start = 1'b1;
      @(negedge Clk);
      chk("en_low_busy", busy, 0);
      start = 1'b0; Enable = 1'b1;
      @(negedge Clk);

      // len=1, no pads, no stalls
      run_frame(12'd1, 3'd0, 0, 0);
      head = '0; svc = '0;
      for (int i = 0; i < 24; i++) if (i < got.size()) head[23-i] = got[i];
      for (int i = 0; i < 8; i++)  if (24 + PB + i < got.size()) svc[7-i] = got[24+PB+i];
      chk("t1_pre_hdr", head, 24'hFFF001);
      chk("t1_service", svc, 8'h0E);
      chk("t1_done_cyc", done_cyc, 55 + PB);
      chk("t1_nvalid", nv, 54 + PB);
      build_exp(12'd1, 3'd0);
      cmp_stream("t1");

      // back-to-back: start right after done cycle, len=2 pads=1, stalls every other DATA cycle
      run_frame(12'd2, 3'd1, 1, 0);
      chk("t2_nvalid", nv, 70 + PB);
      build_exp(12'd2, 3'd1);
      cmp_stream("t2");

      // len=0, pads=0: DATA and PAD skipped
      run_frame(12'd0, 3'd0, 0, 0);
      chk("t3_nvalid", nv, 46 + PB);
      chk("t3_no_ready", saw_ready, 0);
      chk("t3_done_cyc", done_cyc, 47 + PB);
      build_exp(12'd0, 3'd0);
      cmp_stream("t3");

      // start during HEADER is ignored
      run_frame(12'd1, 3'd0, 0, 1);
      chk("t4_done_cyc", done_cyc, 55 + PB);
      build_exp(12'd1, 3'd0);
      cmp_stream("t4");

      // len=7 header (parity bit 1 when enabled)
      run_frame(12'h007, 3'd0, 0, 0);
      head = '0;
      for (int i = 0; i < 12 + PB; i++) if (12 + i < got.size()) head[23-i] = got[12+i];
      chk("t5_header", head, (PB == 1) ? 24'h007800 : 24'h007000);
      chk("t5_nvalid", nv, 102 + PB);

      // reset pulsed mid-DATA, then a clean frame
      len = 12'd2; num_pads = 3'd0; start = 1'b1;
      @(negedge Clk);
      start = 1'b0;
      w = 0;
      while (!data_ready && w < 100) begin @(negedge Clk); w++; end
      chk("t6_reach_data", data_ready, 1);
      repeat (3) @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0; data_in = 1'b1; data_valid = 1'b1;
      #1;
      chk("t6_y", y, 0);
      chk("t6_yv", y_valid, 0);
      chk("t6_busy", busy, 0);
      @(negedge Clk);
      run_frame(12'd2, 3'd0, 0, 0);
      build_exp(12'd2, 3'd0);
      cmp_stream("t6");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
